// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 constants and total helpers.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } timing_t;

    localparam timing_t VGA_640_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam timing_t VGA_480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

    localparam logic VGA_SYNC_ACTIVE = 1'b0;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_if.sv
// Raster output bundle from the timing generator to the screen-memory read path.
interface vga_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 10
);
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (output hsync, vsync, de, x, y, line_start, frame_start);
    modport slave  (input  hsync, vsync, de, x, y, line_start, frame_start);
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single-bit cross-domain flag.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    // Two-stage capture; both stages clear on reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; raster held idle until the PLL lock is synchronized.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 32'(VGA_640_H.active),
    parameter int unsigned H_FP        = 32'(VGA_640_H.fp),
    parameter int unsigned H_SYNC      = 32'(VGA_640_H.sync),
    parameter int unsigned H_BP        = 32'(VGA_640_H.bp),
    parameter int unsigned V_ACTIVE    = 32'(VGA_480_V.active),
    parameter int unsigned V_FP        = 32'(VGA_480_V.fp),
    parameter int unsigned V_SYNC      = 32'(VGA_480_V.sync),
    parameter int unsigned V_BP        = 32'(VGA_480_V.bp),
    parameter logic        SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic  clock,
    input  logic  resetn,
    input  logic  pll_locked,
    vga_if.master vga
);
    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned XW      = $clog2(H_TOTAL);
    localparam int unsigned YW      = $clog2(V_TOTAL);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_SYNC_B = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] H_SYNC_E = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_SYNC_B = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] V_SYNC_E = YW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_guard
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end

    logic lock_s;
    logic run;

    sync_2ff u_lock_sync (
        .clk_i  (clock),
        .rst_ni (resetn),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    assign run = resetn & lock_s;

    logic [XW-1:0] h_q, h_d;
    logic [YW-1:0] v_q, v_d;

    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          ls_q, ls_d;
    logic          fs_q, fs_d;

    // Raster position: h wraps every line, v advances on the h wrap; idle forces origin.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
        end else begin
            h_d = h_q + XW'(1);
        end
    end

    // Counter registers; reset is covered by run, which is low whenever resetn is low.
    always_ff @(posedge clock) begin
        h_q <= h_d;
        v_q <= v_d;
    end

    // Decode of the current position into next-cycle outputs.
    always_comb begin
        de_d    = (h_q < H_ACT) && (v_q < V_ACT);
        hsync_d = (h_q >= H_SYNC_B && h_q < H_SYNC_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = (v_q >= V_SYNC_B && v_q < V_SYNC_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        x_d     = de_d ? h_q : x_q;
        y_d     = de_d ? v_q : y_q;
        ls_d    = (h_q == '0);
        fs_d    = (h_q == '0) && (v_q == '0);
        if (!run) begin
            de_d    = 1'b0;
            hsync_d = ~SYNC_ACTIVE;
            vsync_d = ~SYNC_ACTIVE;
            x_d     = '0;
            y_d     = '0;
            ls_d    = 1'b0;
            fs_d    = 1'b0;
        end
    end

    // Output registers, one clock behind the counters.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
endmodule
